// File: rtl/sram_responder_if.sv
// SRAM control/address bus between the data-memory controller and the SRAM responder.
// The bidirectional data bus stays a plain inout on the responder.
interface sram_responder_if;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_WE_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_responder.sv
// Device-side model of a 16-bit async-style SRAM: byte-masked word array, optional read
// latency pipeline, bus turnaround control, saturating access counters and a sticky OOB flag.
//
// Bus protocol: every posedge samples one cycle; CE_N low with WE_N low is a write (OE_N
// ignored), CE_N low with WE_N high and OE_N low is a read, anything else is idle. There is
// no back-pressure: every classified cycle is accepted in the cycle it is presented.
module sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 0
) (
  input  logic            clk,
  input  logic            rst,
  sram_responder_if.slave bus,
  inout  wire  [15:0]     SRAM_DQ,
  output logic [15:0]     write_count,
  output logic [15:0]     read_count,
  output logic            oob_error,
  output logic            busy,
  output logic [1:0]      state_dbg,
  output logic            dq_drive
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PIPE  = (READ_LAT > 0) ? READ_LAT : 1;

  // state_dbg encoding: 0 = IDLE, 1 = READ, 2 = WRITE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [15:0] mem [DEPTH];

  logic                  is_write;
  logic                  is_read;
  logic                  addr_oob;
  logic [DEPTH_LOG2-1:0] idx;

  assign is_write = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
  assign is_read  = !bus.SRAM_CE_N &&  bus.SRAM_WE_N && !bus.SRAM_OE_N;
  assign addr_oob = |(bus.SRAM_ADDR >> DEPTH_LOG2);
  assign idx      = bus.SRAM_ADDR[DEPTH_LOG2-1:0];

  // Array is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && is_write && !addr_oob) begin
      if (!bus.SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!bus.SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  logic        p_valid [PIPE];
  logic [17:0] p_addr  [PIPE];
  logic        p_ub_n  [PIPE];
  logic        p_lb_n  [PIPE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) p_valid[i] <= 1'b0;
    end else begin
      p_valid[0] <= is_read && (READ_LAT > 0);
      for (int i = 1; i < PIPE; i++) p_valid[i] <= p_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_addr[0] <= bus.SRAM_ADDR;
    p_ub_n[0] <= bus.SRAM_UB_N;
    p_lb_n[0] <= bus.SRAM_LB_N;
    for (int i = 1; i < PIPE; i++) begin
      p_addr[i] <= p_addr[i-1];
      p_ub_n[i] <= p_ub_n[i-1];
      p_lb_n[i] <= p_lb_n[i-1];
    end
  end

  // Entries that will still be in flight after the next shift keep the FSM in READ.
  logic pipe_pending;
  always_comb begin
    pipe_pending = 1'b0;
    for (int i = 0; i < PIPE - 1; i++) pipe_pending = pipe_pending | p_valid[i];
  end

  logic        head_valid;
  logic [17:0] rd_addr;
  logic        rd_ub_n;
  logic        rd_lb_n;
  logic        rd_oob;
  logic [15:0] rd_word;
  logic [15:0] rd_data;

  // The array is read at pipeline exit, so intervening writes are visible.
  assign head_valid = (READ_LAT == 0) ? 1'b1            : p_valid[PIPE-1];
  assign rd_addr    = (READ_LAT == 0) ? bus.SRAM_ADDR   : p_addr[PIPE-1];
  assign rd_ub_n    = (READ_LAT == 0) ? bus.SRAM_UB_N   : p_ub_n[PIPE-1];
  assign rd_lb_n    = (READ_LAT == 0) ? bus.SRAM_LB_N   : p_lb_n[PIPE-1];
  assign rd_oob     = |(rd_addr >> DEPTH_LOG2);
  assign rd_word    = mem[rd_addr[DEPTH_LOG2-1:0]];

  always_comb begin
    rd_data = 16'h0000;
    if (!rd_oob) begin
      rd_data[15:8] = rd_ub_n ? 8'h00 : rd_word[15:8];
      rd_data[7:0]  = rd_lb_n ? 8'h00 : rd_word[7:0];
    end
  end

  // Combinational on WE_N so a read-to-write turnaround frees the bus immediately.
  assign dq_drive = !rst && is_read && head_valid;
  assign SRAM_DQ  = dq_drive ? rd_data : 16'hzzzz;

  always_comb begin
    state_next = IDLE;
    if (is_write)                     state_next = WRITE;
    else if (is_read || pipe_pending) state_next = READ;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      write_count <= 16'h0000;
      read_count  <= 16'h0000;
      oob_error   <= 1'b0;
    end else begin
      if (is_write && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      if (is_read && read_count != 16'hFFFF)   read_count  <= read_count + 16'd1;
      if ((is_write || is_read) && addr_oob)   oob_error   <= 1'b1;
    end
  end
endmodule
